// File: rtl/vdp_pkg.sv
// Shared definitions for the VDP VRAM arbiter: access FSM encoding,
// port identifiers and the fixed grant-to-ack access length.
package vdp_pkg;

  // One access walks SETUP -> STROBE -> LATCH and returns to IDLE with the ack.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_STROBE = 2'd2,
    ST_LATCH  = 2'd3
  } arb_state_t;

  // Which port owns the access currently in flight.
  typedef enum logic {
    PORT_VID = 1'b0,
    PORT_CPU = 1'b1
  } port_t;

  // Clock cycles from the grant cycle to the cycle carrying the ack pulse.
  localparam int ACCESS_CYCLES = 4;

endpackage

// File: rtl/vdp_vram_arb.sv
// VDP VRAM arbiter: shares one asynchronous SRAM between the video fetch
// port and the CPU port. Video normally wins; a pending CPU request is
// forced through after VID_BURST consecutive video grants.
module vdp_vram_arb
  import vdp_pkg::*;
#(
  parameter int VID_BURST = 4
) (
  input  logic        clk40m,
  input  logic        rst_n,
  input  logic        vid_req,
  input  logic [13:0] vid_a,
  output logic        vid_ack,
  output logic [7:0]  vid_rdata,
  input  logic        cpu_req,
  input  logic        cpu_wr,
  input  logic [13:0] cpu_a,
  input  logic [7:0]  cpu_wdata,
  output logic        cpu_ack,
  output logic [7:0]  cpu_rdata,
  output logic [13:0] sram_a,
  output logic [7:0]  sram_dout,
  output logic        sram_doe,
  input  logic [7:0]  sram_din,
  output logic        sram_we_n,
  output logic        sram_oe_n
);

  localparam int SW = $clog2(VID_BURST + 1);

  arb_state_t    state_reg;
  port_t         owner_reg;
  logic          wr_reg;
  logic [SW-1:0] streak_reg;

  logic vid_ok;
  logic cpu_ok;
  logic streak_full;
  logic grant_cpu;
  logic grant_vid;

  // Grant decision for the current IDLE cycle. A port being acked this
  // cycle cannot be regranted. While video is requesting (even during its
  // own ack cycle) the CPU only gets in once the streak is full, so a held
  // video request keeps its slot between back-to-back fetches.
  always_comb begin
    vid_ok      = vid_req & ~vid_ack;
    cpu_ok      = cpu_req & ~cpu_ack;
    streak_full = (streak_reg == SW'(VID_BURST));
    grant_cpu   = (state_reg == ST_IDLE) & cpu_ok & (~vid_req | streak_full);
    grant_vid   = (state_reg == ST_IDLE) & vid_ok & ~grant_cpu;
  end

  // Count video grants made while the CPU is waiting; saturates at VID_BURST.
  always_ff @(posedge clk40m or negedge rst_n) begin
    if (!rst_n) begin
      streak_reg <= '0;
    end else if (!cpu_req || grant_cpu) begin
      streak_reg <= '0;
    end else if (grant_vid && !streak_full) begin
      streak_reg <= streak_reg + 1'b1;
    end
  end

  // Access sequencer with registered SRAM strobes, acks and read data.
  always_ff @(posedge clk40m or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_IDLE;
      owner_reg <= PORT_VID;
      wr_reg    <= 1'b0;
      sram_a    <= '0;
      sram_dout <= '0;
      sram_doe  <= 1'b0;
      sram_we_n <= 1'b1;
      sram_oe_n <= 1'b1;
      vid_ack   <= 1'b0;
      cpu_ack   <= 1'b0;
      vid_rdata <= '0;
      cpu_rdata <= '0;
    end else begin
      vid_ack <= 1'b0;
      cpu_ack <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (grant_cpu || grant_vid) begin
            state_reg <= ST_SETUP;
            owner_reg <= grant_cpu ? PORT_CPU : PORT_VID;
            wr_reg    <= grant_cpu & cpu_wr;
            sram_a    <= grant_cpu ? cpu_a : vid_a;
            if (grant_cpu && cpu_wr) begin
              sram_dout <= cpu_wdata;
              sram_doe  <= 1'b1;
            end else begin
              sram_oe_n <= 1'b0;
            end
          end
        end
        ST_SETUP: begin
          state_reg <= ST_STROBE;
          if (wr_reg) begin
            sram_we_n <= 1'b0;
          end
        end
        ST_STROBE: begin
          state_reg <= ST_LATCH;
          sram_we_n <= 1'b1;
        end
        ST_LATCH: begin
          state_reg <= ST_IDLE;
          sram_doe  <= 1'b0;
          sram_oe_n <= 1'b1;
          if (owner_reg == PORT_CPU) begin
            cpu_ack <= 1'b1;
            if (!wr_reg) begin
              cpu_rdata <= sram_din;
            end
          end else begin
            vid_ack   <= 1'b1;
            vid_rdata <= sram_din;
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vdp_vram_arb.sv
// Testbench for vdp_vram_arb: SRAM model, cycle-level reference model,
// directed vector table, hand-written corner sequences and random traffic.
module tb_vdp_vram_arb;
  import vdp_pkg::*;

  localparam int BURST = 4;

  logic        clk40m = 1'b0;
  logic        rst_n  = 1'b0;
  logic        vid_req = 1'b0;
  logic [13:0] vid_a = '0;
  logic        vid_ack;
  logic [7:0]  vid_rdata;
  logic        cpu_req = 1'b0;
  logic        cpu_wr = 1'b0;
  logic [13:0] cpu_a = '0;
  logic [7:0]  cpu_wdata = '0;
  logic        cpu_ack;
  logic [7:0]  cpu_rdata;
  logic [13:0] sram_a;
  logic [7:0]  sram_dout;
  logic        sram_doe;
  logic [7:0]  sram_din;
  logic        sram_we_n;
  logic        sram_oe_n;

  int checks = 0;
  int failures = 0;
  int fail_prints = 0;

  always #5 clk40m = ~clk40m;

  vdp_vram_arb #(.VID_BURST(BURST)) dut (
    .clk40m(clk40m), .rst_n(rst_n),
    .vid_req(vid_req), .vid_a(vid_a), .vid_ack(vid_ack), .vid_rdata(vid_rdata),
    .cpu_req(cpu_req), .cpu_wr(cpu_wr), .cpu_a(cpu_a), .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
    .sram_a(sram_a), .sram_dout(sram_dout), .sram_doe(sram_doe), .sram_din(sram_din),
    .sram_we_n(sram_we_n), .sram_oe_n(sram_oe_n)
  );

  function automatic logic [7:0] init_byte(input int i);
    return 8'((i * 37) ^ (i >> 5) ^ 8'h5C);
  endfunction

  // Backdoor preload request, consumed at the next rising edge by both memories.
  bit          pre_en = 1'b0;
  logic [13:0] pre_a = '0;
  logic [7:0]  pre_d = '0;

  // Physical SRAM: writes on a clock edge with we_n low, drives data when oe_n low.
  logic [7:0] sram_mem [0:16383];
  bit         sram_init = 1'b0;
  assign sram_din = sram_oe_n ? 8'hEE : sram_mem[sram_a];
  always @(posedge clk40m) begin
    if (!sram_init) begin
      for (int i = 0; i < 16384; i++) sram_mem[i] <= init_byte(i);
      sram_init <= 1'b1;
    end else begin
      if (pre_en) sram_mem[pre_a] <= pre_d;
      if (!sram_we_n) sram_mem[sram_a] <= sram_dout;
    end
  end

  // Reference model: an access is a phase count 1..3 after the grant, strobes
  // derived from phase and direction, ack on the return to idle.
  logic [7:0]  shadow [0:16383];
  bit          m_init = 1'b0;
  int          m_phase = 0;
  int          m_streak = 0;
  bit          m_owner_cpu = 1'b0;
  bit          m_wr = 1'b0;
  logic        m_vack = 1'b0, m_cack = 1'b0;
  logic [7:0]  m_vrd = '0, m_crd = '0, m_sd = '0;
  logic [13:0] m_sa = '0;

  always @(posedge clk40m or negedge rst_n) begin
    bit v_ok, c_ok, give_c, give_v;
    if (!m_init) begin
      for (int i = 0; i < 16384; i++) shadow[i] <= init_byte(i);
      m_init <= 1'b1;
    end
    if (!rst_n) begin
      m_phase <= 0; m_streak <= 0; m_owner_cpu <= 1'b0; m_wr <= 1'b0;
      m_vack <= 1'b0; m_cack <= 1'b0; m_vrd <= '0; m_crd <= '0; m_sa <= '0; m_sd <= '0;
    end else begin
      v_ok   = vid_req && !m_vack;
      c_ok   = cpu_req && !m_cack;
      give_c = (m_phase == 0) && c_ok && (!vid_req || m_streak == BURST);
      give_v = (m_phase == 0) && v_ok && !give_c;
      if (!cpu_req || give_c) m_streak <= 0;
      else if (give_v && m_streak < BURST) m_streak <= m_streak + 1;
      m_vack <= 1'b0;
      m_cack <= 1'b0;
      if (pre_en) shadow[pre_a] <= pre_d;
      if (m_phase == 3) begin
        m_phase <= 0;
        if (m_owner_cpu) begin
          m_cack <= 1'b1;
          if (!m_wr) m_crd <= shadow[m_sa];
        end else begin
          m_vack <= 1'b1;
          m_vrd  <= shadow[m_sa];
        end
      end else if (m_phase != 0) begin
        if (m_phase == 2 && m_wr) shadow[m_sa] <= m_sd;
        m_phase <= m_phase + 1;
      end else if (give_c || give_v) begin
        m_phase     <= 1;
        m_owner_cpu <= give_c;
        m_wr        <= give_c && cpu_wr;
        m_sa        <= give_c ? cpu_a : vid_a;
        if (give_c && cpu_wr) m_sd <= cpu_wdata;
      end
    end
  end

  // Every cycle: all DUT outputs against the model.
  always @(negedge clk40m) begin
    logic [42:0] got, exp;
    if (m_init) begin
      got = {vid_ack, cpu_ack, vid_rdata, cpu_rdata, sram_a, sram_dout, sram_doe, sram_we_n, sram_oe_n};
      exp = {m_vack, m_cack, m_vrd, m_crd, m_sa, m_sd,
             1'(m_phase != 0 && m_wr), 1'(!(m_phase == 2 && m_wr)), 1'(!(m_phase != 0 && !m_wr))};
      checks++;
      if (got !== exp) begin
        failures++;
        if (fail_prints < 20) begin
          fail_prints++;
          $display("FAIL model_cycle t=%0t got=%h exp=%h (vack,cack,vrd,crd,a,dout,doe,we_n,oe_n)", $time, got, exp);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_we_n"}, sram_we_n, 1);
    chk({tag, "_oe_n"}, sram_oe_n, 1);
    chk({tag, "_doe"}, sram_doe, 0);
    chk({tag, "_a"}, sram_a, 0);
    chk({tag, "_dout"}, sram_dout, 0);
    chk({tag, "_acks"}, {vid_ack, cpu_ack}, 0);
    chk({tag, "_rdata"}, {vid_rdata, cpu_rdata}, 0);
  endtask

  task automatic cyc(input int n);
    repeat (n) begin @(posedge clk40m); @(negedge clk40m); end
  endtask

  task automatic preload(input logic [13:0] a, input logic [7:0] d);
    pre_a = a; pre_d = d; pre_en = 1'b1;
    cyc(1);
    pre_en = 1'b0;
  endtask

  // One access on an otherwise quiet bus; bounded wait for the ack.
  task automatic do_access(input bit is_cpu, input bit wr, input logic [13:0] a, input logic [7:0] d,
                           output int lat, output int we_cnt, output logic [13:0] we_a,
                           output logic [7:0] we_d, output bit acked);
    lat = 0; we_cnt = 0; we_a = '0; we_d = '0; acked = 1'b0;
    if (is_cpu) begin cpu_req = 1'b1; cpu_wr = wr; cpu_a = a; cpu_wdata = d; end
    else begin vid_req = 1'b1; vid_a = a; end
    for (int n = 0; n < 20 && !acked; n++) begin
      cyc(1);
      lat++;
      if (!sram_we_n) begin we_cnt++; we_a = sram_a; we_d = sram_dout; end
      if (is_cpu ? cpu_ack : vid_ack) begin
        acked = 1'b1;
        if (is_cpu) cpu_req = 1'b0; else vid_req = 1'b0;
      end
    end
    if (!acked) begin cpu_req = 1'b0; vid_req = 1'b0; end
  endtask

  typedef struct {
    bit          is_cpu;
    bit          wr;
    logic [13:0] a;
    logic [7:0]  d;
    bit          pre;
    logic [7:0]  pre_d;
    logic [7:0]  exp_vrd;
    logic [7:0]  exp_crd;
  } vec_t;

  initial begin
    vec_t vecs[10];
    int lat, we_cnt, acks, oe_cycles, k;
    logic [13:0] we_a;
    logic [7:0] we_d;
    bit acked;
    int seq[$];
    int ack_t[$];

    vecs[0] = '{1, 1, 14'h1234, 8'hA5, 0, 8'h00, 8'h00, 8'h00};
    vecs[1] = '{1, 0, 14'h0010, 8'h00, 1, 8'h3C, 8'h00, 8'h3C};
    vecs[2] = '{0, 0, 14'h1234, 8'h00, 0, 8'h00, 8'hA5, 8'h3C};
    vecs[3] = '{1, 1, 14'h0010, 8'h5A, 0, 8'h00, 8'hA5, 8'h3C};
    vecs[4] = '{1, 0, 14'h0010, 8'h00, 0, 8'h00, 8'hA5, 8'h5A};
    vecs[5] = '{0, 0, 14'h3FFF, 8'h00, 1, 8'hFF, 8'hFF, 8'h5A};
    vecs[6] = '{0, 0, 14'h0000, 8'h00, 1, 8'h00, 8'h00, 8'h5A};
    vecs[7] = '{1, 0, 14'h3FFF, 8'h00, 0, 8'h00, 8'h00, 8'hFF};
    vecs[8] = '{1, 1, 14'h3FFF, 8'h81, 0, 8'h00, 8'h00, 8'hFF};
    vecs[9] = '{0, 0, 14'h3FFF, 8'h00, 0, 8'h00, 8'h81, 8'hFF};

    cyc(3);
    chk_reset_outputs("reset");
    rst_n = 1'b1;
    cyc(3);
    chk("idle_no_strobes", {sram_we_n, sram_oe_n, sram_doe}, 3'b110);

    // Directed single accesses.
    foreach (vecs[i]) begin
      if (vecs[i].pre) preload(vecs[i].a, vecs[i].pre_d);
      do_access(vecs[i].is_cpu, vecs[i].wr, vecs[i].a, vecs[i].d, lat, we_cnt, we_a, we_d, acked);
      chk($sformatf("v%0d_acked", i), acked, 1);
      chk($sformatf("v%0d_latency", i), lat, ACCESS_CYCLES);
      chk($sformatf("v%0d_we_cycles", i), we_cnt, vecs[i].wr ? 1 : 0);
      if (vecs[i].wr) begin
        chk($sformatf("v%0d_we_addr", i), we_a, vecs[i].a);
        chk($sformatf("v%0d_we_data", i), we_d, vecs[i].d);
      end
      chk($sformatf("v%0d_vid_rdata", i), vid_rdata, vecs[i].exp_vrd);
      chk($sformatf("v%0d_cpu_rdata", i), cpu_rdata, vecs[i].exp_crd);
      cyc(1);
      chk($sformatf("v%0d_ack_pulse", i), {vid_ack, cpu_ack}, 0);
      cyc(2);
    end

    // Both ports raised together and held: video first, then 4 video : 1 CPU.
    vid_a = 14'h0200; vid_req = 1'b1;
    cpu_a = 14'h0300; cpu_wr = 1'b0; cpu_req = 1'b1;
    for (int n = 0; n < 200 && seq.size() < 15; n++) begin
      cyc(1);
      if (vid_ack) seq.push_back(0);
      if (cpu_ack) seq.push_back(1);
    end
    vid_req = 1'b0; cpu_req = 1'b0;
    chk("burst_ack_count", seq.size(), 15);
    for (int j = 0; j < seq.size(); j++)
      chk($sformatf("burst_order_%0d", j), seq[j], (j % 5 == 4) ? 1 : 0);
    cyc(10);

    // CPU read held through three acks with the address stepping each time.
    preload(14'h0100, 8'h11);
    preload(14'h0101, 8'h22);
    preload(14'h0102, 8'h33);
    acks = 0; oe_cycles = 0;
    cpu_wr = 1'b0; cpu_a = 14'h0100; cpu_req = 1'b1;
    for (int n = 0; n < 40; n++) begin
      cyc(1);
      if (!sram_oe_n) oe_cycles++;
      if (cpu_ack) begin
        ack_t.push_back(n);
        chk($sformatf("b2b_rdata_%0d", acks), cpu_rdata, 8'h11 * (acks + 1));
        acks++;
        if (acks < 3) cpu_a = 14'h0100 + 14'(acks);
        else cpu_req = 1'b0;
      end
    end
    chk("b2b_acks", acks, 3);
    chk("b2b_oe_cycles", oe_cycles, 9);
    if (ack_t.size() == 3) begin
      chk("b2b_spacing_1", ack_t[1] - ack_t[0], 5);
      chk("b2b_spacing_2", ack_t[2] - ack_t[1], 5);
    end

    // Reset asserted during the STROBE cycle of a write.
    preload(14'h0ABC, 8'h11);
    cpu_wr = 1'b1; cpu_a = 14'h0ABC; cpu_wdata = 8'h77; cpu_req = 1'b1;
    acked = 1'b0;
    for (int n = 0; n < 20 && !acked; n++) begin
      cyc(1);
      if (!sram_we_n) acked = 1'b1;
    end
    chk("rst_saw_strobe", acked, 1);
    #2 rst_n = 1'b0;
    #1 chk_reset_outputs("rst_mid");
    cpu_req = 1'b0;
    cyc(2);
    rst_n = 1'b1;
    acks = 0;
    for (int n = 0; n < 6; n++) begin
      cyc(1);
      if (cpu_ack || vid_ack) acks++;
    end
    chk("rst_no_ack", acks, 0);
    rst_n = 1'b0;
    cyc(1);
    // Request already up when reset releases: granted in the first clock.
    cpu_wr = 1'b0; cpu_a = 14'h0ABC; cpu_req = 1'b1;
    rst_n = 1'b1;
    do_access(1, 0, 14'h0ABC, 8'h00, lat, we_cnt, we_a, we_d, acked);
    chk("rst_first_grant_latency", lat, ACCESS_CYCLES);
    chk("rst_write_aborted", cpu_rdata, 8'h11);
    cyc(3);

    // Random traffic checked cycle by cycle against the model.
    acks = 0;
    for (int n = 0; n < 3000; n++) begin
      if (vid_ack) acks++;
      if (cpu_ack) acks++;
      if (!vid_req) begin
        if ($urandom_range(0, 2) == 0) begin vid_a = 14'($urandom_range(0, 31)); vid_req = 1'b1; end
      end else if (vid_ack) begin
        if ($urandom_range(0, 1) == 0) vid_req = 1'b0;
      end else if ($urandom_range(0, 39) == 0) begin
        vid_req = 1'b0;
      end
      if (!cpu_req || cpu_ack) begin
        if (cpu_req && $urandom_range(0, 1) == 0) cpu_req = 1'b0;
        else if (cpu_req || $urandom_range(0, 2) == 0) begin
          cpu_req = 1'b1;
          cpu_wr = 1'($urandom_range(0, 1));
          cpu_a = 14'($urandom_range(0, 31));
          cpu_wdata = 8'($urandom);
        end
      end else if ($urandom_range(0, 39) == 0) begin
        cpu_req = 1'b0;
      end
      cyc(1);
    end
    vid_req = 1'b0; cpu_req = 1'b0;
    cyc(10);
    k = (acks >= 100) ? 1 : 0;
    chk("random_liveness", k, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog timeout t=%0t", $time);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/vdp_vram_arb.md
VDP_VRAM_ARB -- requirements
Module: vdp_vram_arb

Interface
REQ-001 Parameter: VID_BURST, default 4, max consecutive video grants while CPU request pending.
REQ-002 clk40m  input  1  system clock; all state on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 vid_req  input  1  video fetch request, level, held until vid_ack.
REQ-005 vid_a  input  14  video fetch address, stable while vid_req high.
REQ-006 vid_ack  output  1  one-cycle pulse, video read complete.
REQ-007 vid_rdata  output  8  video read data, valid during vid_ack, held until next video read.
REQ-008 cpu_req  input  1  CPU port request, level, held until cpu_ack; may stay high through ack for back-to-back.
REQ-009 cpu_wr  input  1  CPU access is write when high.
REQ-010 cpu_a  input  14  CPU address.
REQ-011 cpu_wdata  input  8  CPU write data.
REQ-012 cpu_ack  output  1  one-cycle pulse, CPU access complete.
REQ-013 cpu_rdata  output  8  CPU read data, valid during cpu_ack, held until next CPU read.
REQ-014 sram_a  output  14  SRAM address.
REQ-015 sram_dout  output  8  SRAM write data.
REQ-016 sram_doe  output  1  SRAM data bus drive enable.
REQ-017 sram_din  input  8  SRAM read data.
REQ-018 sram_we_n  output  1  SRAM write strobe, active-low.
REQ-019 sram_oe_n  output  1  SRAM output enable, active-low.

Function
REQ-020 FSM states IDLE, SETUP, STROBE, LATCH; every access is SETUP->STROBE->LATCH->IDLE, one cycle each.
REQ-021 Grant evaluated only in IDLE; port's address, wr flag, wdata latched at grant; FSM enters SETUP next cycle.
REQ-022 A port whose ack is high in current cycle is ineligible for grant in that cycle.
REQ-023 Priority: video over CPU, except CPU wins when streak counter equals VID_BURST and cpu_req eligible.
REQ-024 Streak counter increments on each video grant while cpu_req high, clears on CPU grant or when cpu_req low; saturates at VID_BURST.
REQ-025 Read: sram_oe_n low in SETUP, STROBE, LATCH; sram_doe low; sram_din sampled into port rdata register at end of LATCH.
REQ-026 Write: sram_doe high SETUP..LATCH; sram_we_n low only in STROBE; sram_oe_n high throughout.
REQ-027 sram_a driven from latched address SETUP..LATCH; holds last value in IDLE.
REQ-028 Ack pulsed exactly one cycle, in the IDLE cycle following LATCH, to granted port only; latency grant-to-ack = 4 cycles.
REQ-029 Back-to-back: port holding req through ack regranted no earlier than cycle after ack (5-cycle access period).
REQ-030 Both ports idle: FSM stays IDLE, all SRAM strobes inactive.
REQ-031 Requests dropped before grant are discarded silently; requests dropped after grant still complete and ack.
REQ-032 vid_rdata unchanged by CPU accesses; cpu_rdata unchanged by video and CPU-write accesses.

Reset
REQ-033 rst_n low forces immediately: state IDLE, sram_we_n=1, sram_oe_n=1, sram_doe=0, sram_a=0, sram_dout=0, vid_ack=0, cpu_ack=0, vid_rdata=0, cpu_rdata=0, streak=0.
REQ-034 Reset mid-access aborts access with no ack; first grant possible in first clock after rst_n rises.

Structure
REQ-035 FSM state encoding and access-length constant reside in shared package vdp_pkg.
REQ-036 Single flat module; no sub-module.
REQ-037 All outputs registered; no combinational path input to output.

Verification
REQ-038 CPU write a=0x1234 d=0xA5 alone -> sram_we_n low exactly one cycle with sram_a=0x1234, sram_dout=0xA5; cpu_ack 4 cycles after grant.
REQ-039 CPU read a=0x0010, sram_din=0x3C -> cpu_ack one cycle, cpu_rdata=0x3C; sram_we_n never low.
REQ-040 vid_req and cpu_req raised same cycle -> video granted first, CPU granted at next eligible IDLE.
REQ-041 vid_req held continuously, cpu_req high -> after 4 video acks CPU granted, then video resumes; repeat pattern 4:1.
REQ-042 CPU req held through 3 acks (address auto-changing 0x0100..0x0102) -> three accesses, ack spacing 5 cycles, no duplicate access.
REQ-043 rst_n low during STROBE of write -> sram_we_n high same cycle, no ack, all outputs at reset values.
